video_timing_generator: RTL

VIDEO_TIMING_GENERATOR -- requirements
Module: video_timing_generator

---
 rtl/video_timing_pkg.sv | 34 +++
 rtl/video_timing_generator_pos_counter.sv | 73 +++++++
 rtl/video_timing_generator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared constants for the video timing generator: the 640x480@60 default
// segment widths and a helper that turns the four segment widths of one axis
// into that axis' total period.
// -----------------------------------------------------------------------------
package video_timing_pkg;

  // Horizontal segments, in pixels
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  // Vertical segments, in lines
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_BOTTOM  = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_TOP     = 33;

  // Sync polarities (0 = active low), lookahead and counter widths
  localparam int DEF_H_SYNC_POL = 0;
  localparam int DEF_V_SYNC_POL = 0;
  localparam int DEF_LOOKAHEAD  = 2;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_FRAME_W    = 8;

  // Total period of one axis from its display, front, sync and back segments
  function automatic int calc_total(input int disp, input int front,
                                    input int sync, input int back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_generator_pos_counter.sv
// -----------------------------------------------------------------------------
// pos_counter
// Wrapping horizontal/vertical counter pair. The horizontal count advances on
// every enabled clock and wraps H_TOTAL-1 -> 0; the vertical count advances
// only on that wrap and itself wraps V_TOTAL-1 -> 0 in the same cycle.
// A synchronous active-high reset loads (H_INIT, V_INIT) regardless of en.
//
// Ports:
//   clk   in   clock
//   reset in   synchronous active-high reset
//   en    in   count enable
//   hcnt  out  CNT_W horizontal count
//   vcnt  out  CNT_W vertical count
// -----------------------------------------------------------------------------
module pos_counter
  import video_timing_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_INIT  = 0,
  parameter int V_INIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_INIT);
  localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_INIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] hcnt_r;
  logic [CNT_W-1:0] vcnt_r;
  logic [CNT_W-1:0] hcnt_next_s;
  logic [CNT_W-1:0] vcnt_next_s;

  // Next position: step one pixel, carrying into the line count on wrap
  always_comb begin
    hcnt_next_s = hcnt_r;
    vcnt_next_s = vcnt_r;
    if (hcnt_r == H_LAST) begin
      hcnt_next_s = CNT_ZERO;
      if (vcnt_r == V_LAST) begin
        vcnt_next_s = CNT_ZERO;
      end else begin
        vcnt_next_s = vcnt_r + CNT_ONE;
      end
    end else begin
      hcnt_next_s = hcnt_r + CNT_ONE;
    end
  end

  // Position register: reset load wins over the enable
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_r <= H_START;
      vcnt_r <= V_START;
    end else if (en) begin
      hcnt_r <= hcnt_next_s;
      vcnt_r <= vcnt_next_s;
    end
  end

  assign hcnt = hcnt_r;
  assign vcnt = vcnt_r;

endmodule

// File: rtl/video_timing_generator.sv
// -----------------------------------------------------------------------------
// video_timing_generator
// Raster timing generator. Two pos_counter instances run in lockstep: one
// tracks the current pixel, the other starts LOOKAHEAD pixels further on and
// therefore stays exactly that far ahead across line and frame wraps. All
// sync/visibility outputs are decoded combinationally from the current
// position so they describe the same pixel as hpos/vpos.
//
// Optional feature: define VTG_FRAME_COUNTER_EN to build the completed-frame
// counter; otherwise frame_count is tied to 0 and no register exists.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   pix_ce       in   pixel clock enable
//   hpos, vpos   out  raw position counters
//   screen_hpos  out  hpos when visible, else 0
//   screen_vpos  out  vpos when visible, else 0
//   ahead_hpos   out  position LOOKAHEAD enabled pixels ahead (horizontal)
//   ahead_vpos   out  position LOOKAHEAD enabled pixels ahead (vertical)
//   hsync, vsync out  sync pulses at the configured polarities
//   display_on   out  current pixel is in the visible area
//   line_start   out  pulse on the enabled cycle at hpos==0
//   frame_start  out  pulse on the enabled cycle at (0,0)
//   frame_count  out  completed frame count
// -----------------------------------------------------------------------------
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int H_DISPLAY  = DEF_H_DISPLAY,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_DISPLAY  = DEF_V_DISPLAY,
  parameter int V_BOTTOM   = DEF_V_BOTTOM,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_TOP      = DEF_V_TOP,
  parameter int H_SYNC_POL = DEF_H_SYNC_POL,
  parameter int V_SYNC_POL = DEF_V_SYNC_POL,
  parameter int LOOKAHEAD  = DEF_LOOKAHEAD,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FRAME_W    = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_ce,
  output logic [CNT_W-1:0]   hpos,
  output logic [CNT_W-1:0]   vpos,
  output logic [CNT_W-1:0]   screen_hpos,
  output logic [CNT_W-1:0]   screen_vpos,
  output logic [CNT_W-1:0]   ahead_hpos,
  output logic [CNT_W-1:0]   ahead_vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = calc_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = calc_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);

  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_DISPLAY + V_BOTTOM);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam logic             H_ACTIVE   = 1'(H_SYNC_POL);
  localparam logic             V_ACTIVE   = 1'(V_SYNC_POL);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  logic in_hsync_s;
  logic in_vsync_s;
  logic visible_s;
  logic line_start_s;

  // Current pixel position
  pos_counter #(
    .CNT_W  (CNT_W),
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL),
    .H_INIT (0),
    .V_INIT (0)
  ) u_main_pos (
    .clk  (clk),
    .reset(reset),
    .en   (pix_ce),
    .hcnt (hpos),
    .vcnt (vpos)
  );

  // Lookahead position: starts LOOKAHEAD pixels into line 0 and is enabled
  // identically, so the distance to the main counter never changes
  pos_counter #(
    .CNT_W  (CNT_W),
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL),
    .H_INIT (LOOKAHEAD),
    .V_INIT (0)
  ) u_ahead_pos (
    .clk  (clk),
    .reset(reset),
    .en   (pix_ce),
    .hcnt (ahead_hpos),
    .vcnt (ahead_vpos)
  );

  // Zero-latency decode of the current pixel
  always_comb begin
    in_hsync_s   = (hpos >= HS_FIRST) && (hpos <= HS_LAST);
    in_vsync_s   = (vpos >= VS_FIRST) && (vpos <= VS_LAST);
    visible_s    = (hpos < H_VIS) && (vpos < V_VIS);
    line_start_s = (hpos == CNT_ZERO) && pix_ce;
  end

  assign hsync       = in_hsync_s ? H_ACTIVE : ~H_ACTIVE;
  assign vsync       = in_vsync_s ? V_ACTIVE : ~V_ACTIVE;
  assign display_on  = visible_s;
  assign screen_hpos = visible_s ? hpos : CNT_ZERO;
  assign screen_vpos = visible_s ? vpos : CNT_ZERO;
  assign line_start  = line_start_s;
  assign frame_start = line_start_s && (vpos == CNT_ZERO);

`ifdef VTG_FRAME_COUNTER_EN
  logic [FRAME_W-1:0] frame_count_r;

  // Completed-frame counter, bumped on each frame_start edge outside reset
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_r <= {FRAME_W{1'b0}};
    end else if (frame_start) begin
      frame_count_r <= frame_count_r + {{(FRAME_W-1){1'b0}}, 1'b1};
    end
  end

  assign frame_count = frame_count_r;
`else
  assign frame_count = {FRAME_W{1'b0}};
`endif

endmodule
